// File: rtl/openofdm_rx_cfg_axi.sv
// openofdm_rx_cfg_axi: AXI4-Lite slave exposing config registers with write pulses/self-clear and snapshotted status registers
module openofdm_rx_cfg_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_CFG_REGS = 20,
  parameter int NUM_STAT_REGS = 12,
  parameter int STAT_BASE = 20,
  parameter logic [NUM_CFG_REGS*32-1:0] CFG_RESET_VAL = '0,
  parameter logic [31:0] SELF_CLR_MASK = 32'h0000_0001
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [3:0]                      s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_CFG_REGS*32-1:0]      cfg_out,
  output logic [NUM_CFG_REGS-1:0]         cfg_wr_pulse,
  input  logic [NUM_STAT_REGS*32-1:0]     stat_in
);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic [31:0] w_idx, r_idx, rd_data;
  logic [1:0] rd_resp;
  logic w_cfg;
  logic [NUM_STAT_REGS*32-1:0] snap;
  logic unused_ok;
  assign w_idx = 32'(s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign r_idx = 32'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);
  assign w_cfg = w_idx < NUM_CFG_REGS;
  assign s00_axi_wready = s00_axi_awready;
  assign s00_axi_bvalid = w_state == W_RESP;
  assign s00_axi_rvalid = r_state == R_DATA;
  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0], snap[31:0]};
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  // ready is gated by aresetn so nothing handshakes while reset is held
  always_comb begin
    s00_axi_awready = s00_axi_aresetn && w_state == W_IDLE && s00_axi_awvalid && s00_axi_wvalid;
    s00_axi_arready = s00_axi_aresetn && r_state == R_IDLE && s00_axi_arvalid;
    w_next = s00_axi_awready ? W_RESP : (w_state == W_RESP && s00_axi_bready) ? W_IDLE : w_state;
    r_next = s00_axi_arready ? R_DATA : (r_state == R_DATA && s00_axi_rready) ? R_IDLE : r_state;
  end
  // status word 0 is read live; the rest come from the snapshot taken by the word-0 read
  always_comb begin
    rd_data = '0;
    rd_resp = 2'b10;
    for (int i = 0; i < NUM_CFG_REGS; i++)
      if (r_idx == i) begin
        rd_data = cfg_out[32*i +: 32];
        rd_resp = 2'b00;
      end
    for (int k = 0; k < NUM_STAT_REGS; k++)
      if (r_idx == STAT_BASE + k) begin
        rd_data = k == 0 ? stat_in[31:0] : snap[32*k +: 32];
        rd_resp = 2'b00;
      end
  end
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
    if (!s00_axi_aresetn) begin
      cfg_out <= CFG_RESET_VAL;
      cfg_wr_pulse <= '0;
      s00_axi_bresp <= 2'b00;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= 2'b00;
      snap <= '0;
    end else begin
      cfg_out[31:0] <= cfg_out[31:0] & ~SELF_CLR_MASK;
      for (int i = 0; i < NUM_CFG_REGS; i++) begin
        cfg_wr_pulse[i] <= s00_axi_awready && w_idx == i;
        for (int b = 0; b < 4; b++)
          if (s00_axi_awready && w_idx == i && s00_axi_wstrb[b]) cfg_out[32*i+8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
      if (s00_axi_awready) s00_axi_bresp <= w_cfg ? 2'b00 : 2'b10;
      if (s00_axi_arready) begin
        s00_axi_rdata <= rd_data;
        s00_axi_rresp <= rd_resp;
      end
      if (s00_axi_arready && r_idx == STAT_BASE) snap <= stat_in;
    end
endmodule

// File: tb/tb_openofdm_rx_cfg_axi.sv
// tb_openofdm_rx_cfg_axi: table, hand-sequence and random checks of the AXI4-Lite config/status slave
module tb_openofdm_rx_cfg_axi;
  localparam int AW = 8, NC = 20, NS = 12, SB = 20;
  logic clk = 1'b0, rstn = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [NC*32-1:0] cfg_out;
  logic [NC-1:0] cfg_wr_pulse;
  logic [NS*32-1:0] stat_in;
  logic [31:0] st [NS];
  logic [31:0] m_cfg [NC];
  logic [31:0] m_snap [NS];
  int n_vec = 0, n_err = 0;
  typedef struct {
    bit wr;
    int idx;
    logic [31:0] d;
    logic [3:0] s;
    logic [31:0] ed;
    logic [1:0] er;
  } vec_t;
  vec_t tab [16];
  always #5 clk = ~clk;
  always_comb for (int k = 0; k < NS; k++) stat_in[32*k +: 32] = st[k];
  openofdm_rx_cfg_axi #(.C_S_AXI_ADDR_WIDTH(AW)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rstn),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .cfg_out(cfg_out), .cfg_wr_pulse(cfg_wr_pulse), .stat_in(stat_in)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
    return o;
  endfunction
  function automatic logic [NC*32-1:0] img();
    logic [NC*32-1:0] v;
    for (int i = 0; i < NC; i++) v[32*i +: 32] = m_cfg[i];
    return v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < NC; i++) m_cfg[i] = '0;
    for (int k = 0; k < NS; k++) m_snap[k] = '0;
  endtask
  task automatic mwrite(input int idx, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
    int t;
    logic ok;
    logic [NC-1:0] p1;
    t = 0;
    ok = idx < NC;
    awaddr = AW'(idx * 4); wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    while (!awready && t < 20) begin @(posedge clk); #1; t++; end
    chk("aw_timeout", 32'(t < 20), 32'd1);
    chk("wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_lat", 32'(bvalid), 32'd1);
    resp = bresp;
    p1 = cfg_wr_pulse;
    if (ok) begin
      m_cfg[idx] = merge(m_cfg[idx], d, s);
      chk("cfg_now", cfg_out[32*idx +: 32], m_cfg[idx]);
      if (idx == 0) m_cfg[0] = m_cfg[0] & ~32'h1;
    end
    chk("pulse", 32'(p1), ok ? 32'd1 << idx : 32'd0);
    chk("bresp", 32'(resp), ok ? 32'd0 : 32'd2);
    @(posedge clk); #1;
    bready = 1'b0;
    chk("pulse_off", 32'(cfg_wr_pulse), 32'd0);
    chk("bvalid_off", 32'(bvalid), 32'd0);
    chk("cfg_img", 32'(cfg_out == img()), 32'd1);
  endtask
  task automatic mread(input int idx, output logic [31:0] d, output logic [1:0] r);
    int t;
    logic [31:0] ed;
    logic [1:0] er;
    t = 0;
    araddr = AW'(idx * 4); arvalid = 1'b1; rready = 1'b1;
    #1;
    while (!arready && t < 20) begin @(posedge clk); #1; t++; end
    chk("ar_timeout", 32'(t < 20), 32'd1);
    er = 2'd0;
    if (idx < NC) ed = m_cfg[idx];
    else if (idx == SB) begin ed = st[0]; m_snap = st; end
    else if (idx < SB + NS) ed = m_snap[idx - SB];
    else begin ed = '0; er = 2'd2; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rvalid_lat", 32'(rvalid), 32'd1);
    d = rdata;
    r = rresp;
    chk("rdata", d, ed);
    chk("rresp", 32'(r), 32'(er));
    @(posedge clk); #1;
    rready = 1'b0;
    chk("rvalid_off", 32'(rvalid), 32'd0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int idx;
    for (int k = 0; k < NS; k++) st[k] = '0;
    model_reset();
    tab[0]  = '{1'b0, 3,  32'h0,        4'h0, 32'h0,        2'd0};
    tab[1]  = '{1'b1, 2,  32'hAABBCCDD, 4'h5, 32'h0,        2'd0};
    tab[2]  = '{1'b0, 2,  32'h0,        4'h0, 32'h00BB00DD, 2'd0};
    tab[3]  = '{1'b1, 22, 32'h12345678, 4'hF, 32'h0,        2'd2};
    tab[4]  = '{1'b0, 40, 32'h0,        4'h0, 32'h0,        2'd2};
    tab[5]  = '{1'b1, 0,  32'h1,        4'hF, 32'h0,        2'd0};
    tab[6]  = '{1'b0, 0,  32'h0,        4'h0, 32'h0,        2'd0};
    tab[7]  = '{1'b1, 0,  32'h1,        4'h1, 32'h0,        2'd0};
    tab[8]  = '{1'b1, 5,  32'h12345678, 4'hF, 32'h0,        2'd0};
    tab[9]  = '{1'b1, 5,  32'hFFFFFFFF, 4'h8, 32'h0,        2'd0};
    tab[10] = '{1'b0, 5,  32'h0,        4'h0, 32'hFF345678, 2'd0};
    tab[11] = '{1'b1, 19, 32'hDEADBEEF, 4'h0, 32'h0,        2'd0};
    tab[12] = '{1'b0, 19, 32'h0,        4'h0, 32'h0,        2'd0};
    tab[13] = '{1'b1, 63, 32'hFFFFFFFF, 4'hF, 32'h0,        2'd2};
    tab[14] = '{1'b0, 63, 32'h0,        4'h0, 32'h0,        2'd2};
    tab[15] = '{1'b0, 2,  32'h0,        4'h0, 32'h00BB00DD, 2'd0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_cfg", 32'(cfg_out == img()), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    foreach (tab[i]) begin
      if (tab[i].wr) begin
        mwrite(tab[i].idx, tab[i].d, tab[i].s, r);
        chk("tab_bresp", 32'(r), 32'(tab[i].er));
      end else begin
        mread(tab[i].idx, d, r);
        chk("tab_rdata", d, tab[i].ed);
        chk("tab_rresp", 32'(r), 32'(tab[i].er));
      end
    end
    st[0] = 32'd5; st[1] = 32'd7;
    mread(20, d, r); chk("snap_w0", d, 32'd5);
    st[1] = 32'd9;
    mread(21, d, r); chk("snap_old", d, 32'd7);
    mread(20, d, r);
    mread(21, d, r); chk("snap_new", d, 32'd9);
    mwrite(4, 32'h11112222, 4'hF, r);
    awaddr = AW'(16); wdata = 32'h33334444; wstrb = 4'hF; araddr = AW'(16);
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    #1;
    chk("both_ready", 32'({awready, arready}), 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_edge_rd", rdata, 32'h11112222);
    m_cfg[4] = 32'h33334444;
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    chk("same_edge_img", 32'(cfg_out == img()), 32'd1);
    mwrite(7, 32'hCAFEF00D, 4'hF, r);
    araddr = AW'(28); arvalid = 1'b1; rready = 1'b0;
    #1;
    chk("hold_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    awaddr = AW'(12); wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    #1;
    chk("hold_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      chk("hold_bvalid", 32'(bvalid), 32'd1);
      chk("hold_no_awready", 32'(awready), 32'd0);
      chk("hold_bresp", 32'(bresp), 32'd0);
      chk("hold_rvalid", 32'(rvalid), 32'd1);
      chk("hold_rdata", rdata, 32'hCAFEF00D);
      @(posedge clk); #1;
    end
    arvalid = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    chk("arst_awready", 32'({awready, wready, arready}), 32'd0);
    chk("arst_valid", 32'({bvalid, rvalid}), 32'd0);
    chk("arst_resp", 32'({bresp, rresp}), 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    chk("arst_pulse", 32'(cfg_wr_pulse), 32'd0);
    chk("arst_cfg", 32'(cfg_out == img()), 32'd1);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    mread(7, d, r); chk("post_rst_cfg", d, 32'd0);
    mread(21, d, r); chk("post_rst_snap", d, 32'd0);
    for (int n = 0; n < 300; n++) begin
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 31));
      for (int k = 0; k < NS; k++) st[k] = $urandom;
      if ($urandom_range(0, 1) == 1) mwrite(idx, $urandom, 4'($urandom), r);
      else mread(idx, d, r);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/openofdm_rx_cfg_axi.md
Name: openofdm_rx_cfg_axi

Overview:
- Parametrised AXI4-Lite register slave for the OFDM receiver core; successor to the fixed 5-config/1-status register slave.
- Provides NUM_CFG_REGS read/write config registers, NUM_STAT_REGS read-only status registers, byte-strobe writes, per-register write pulses, self-clearing bits and coherent status snapshots.
- Sits between the PS AXI interconnect and the dot11 core: cfg_out drives reset/enable/thresholds; stat_in carries state history and counters.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 7, byte-address width; word index = awaddr/araddr[C_S_AXI_ADDR_WIDTH-1:2].
- NUM_CFG_REGS, 20, config registers at word index 0..NUM_CFG_REGS-1.
- NUM_STAT_REGS, 12, status registers at word index STAT_BASE..STAT_BASE+NUM_STAT_REGS-1.
- STAT_BASE, 20, first status word index; must be >= NUM_CFG_REGS; top of status range must be < 2^(C_S_AXI_ADDR_WIDTH-2).
- CFG_RESET_VAL, all zeros, flat NUM_CFG_REGS*32 reset image; register i = bits [32i+31:32i].
- SELF_CLR_MASK, 32'h00000001, bits of config reg 0 that self-clear.

Ports:
- s00_axi_aclk  in  1  clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address.
- s00_axi_awprot  in  3  ignored.
- s00_axi_awvalid  in  1  write address valid.
- s00_axi_awready  out  1  write address ready.
- s00_axi_wdata  in  32  write data.
- s00_axi_wstrb  in  4  byte enables.
- s00_axi_wvalid  in  1  write data valid.
- s00_axi_wready  out  1  write data ready.
- s00_axi_bresp  out  2  write response.
- s00_axi_bvalid  out  1  write response valid.
- s00_axi_bready  in  1  write response ready.
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address.
- s00_axi_arprot  in  3  ignored.
- s00_axi_arvalid  in  1  read address valid.
- s00_axi_arready  out  1  read address ready.
- s00_axi_rdata  out  32  read data.
- s00_axi_rresp  out  2  read response.
- s00_axi_rvalid  out  1  read data valid.
- s00_axi_rready  in  1  read data ready.
- cfg_out  out  NUM_CFG_REGS*32  current config register image.
- cfg_wr_pulse  out  NUM_CFG_REGS  one-cycle strobe per register on a committed write.
- stat_in  in  NUM_STAT_REGS*32  live status inputs, already synchronous to s00_axi_aclk.

Behaviour:
- Reset (async assert, sync release): awready, wready, bvalid, arready, rvalid = 0; bresp, rresp = 2'b00; rdata = 0; cfg_out = CFG_RESET_VAL; cfg_wr_pulse = 0; snapshot = 0. Reset mid-transaction discards the transaction; no response is issued.
- Write FSM, states W_IDLE -> W_RESP:
  - In W_IDLE, when awvalid && wvalid && !bvalid: awready = wready = 1 for exactly one cycle.
  - The write commits on that same edge; the FSM moves to W_RESP with bvalid = 1 next cycle.
  - Address and data are never accepted separately; a lone awvalid or lone wvalid waits.
  - W_RESP holds bvalid/bresp until bready, then returns to W_IDLE. Earliest next awready is the cycle after the bvalid&&bready handshake.
- Write decode:
  - Index < NUM_CFG_REGS: for each byte b with wstrb[b]=1, reg[idx][8b+7:8b] = wdata[8b+7:8b]; cfg_wr_pulse[idx] = 1 the following cycle for one cycle, even when wstrb = 0; bresp = OKAY (2'b00).
  - Status range or unmapped index: no state change; no pulse; bresp = SLVERR (2'b10).
- Self-clear: bits of cfg reg 0 set by a write under SELF_CLR_MASK read 1 on cfg_out for exactly one cycle, then return to 0. A back-to-back rewrite re-asserts them.
- Read FSM, states R_IDLE -> R_DATA:
  - In R_IDLE, when arvalid && !rvalid: arready = 1 for one cycle; rdata/rresp are registered; rvalid = 1 next cycle.
  - R_DATA holds rdata, rresp and rvalid until rready.
  - Read latency from the arvalid&&arready handshake to rvalid = 1 cycle.
- Read decode:
  - Config index: current register value; OKAY.
  - Index STAT_BASE: returns live stat_in word 0, and on the same edge copies all of stat_in into the snapshot; OKAY.
  - Index STAT_BASE+k, k >= 1: returns snapshot word k; OKAY.
  - Unmapped index: rdata = 0; SLVERR.
- Simultaneous read and write handshakes on the same edge to the same config reg: the read returns the pre-write value.
- Read and write channels are fully independent; no ordering between them.

Test Plan:
- Reset, then read word 3 -> rdata = 32'h0 (CFG_RESET_VAL), rresp = 00, rvalid asserted 1 cycle after the arready cycle.
- Write word 2 = 32'hAABBCCDD with wstrb = 4'b0101, old value 0 -> cfg reg 2 = 32'h00BB00DD; cfg_wr_pulse[2] high for one cycle; bresp = 00; readback = 32'h00BB00DD.
- Write word 0 = 32'h1 -> cfg_out[0] high for exactly one cycle; readback of word 0 = 0.
- With stat_in words 0/1 = 5/7: read word 20 -> 5; change word 1 to 9, read word 21 -> 7; read word 20 again, then word 21 -> 9.
- Write word 22 (status) and read word 40 (unmapped) -> bresp = 10, no cfg change or pulse; rresp = 10, rdata = 0.
- Hold bready = 0 for 5 cycles after a write -> bvalid held and no new awready; then assert aresetn = 0 mid-transaction -> all outputs at reset values immediately.
